radix_str_seq: RTL and testbench

Sequential ASCII-numeral-to-binary converter for the radix-conversion path. It accepts a right-aligned ASCII string and a base (2..16) over a valid/ready handshake. It scans one character per clock, MSB first, accumulating `value*base + digit`, and returns the result with error flags over a second valid/ready handshake. It replaces the single-cycle string converter where timing or area requires a serial datapath.

---
 rtl/radix_pkg.sv | 21 ++
 rtl/radix_char_decode.sv | 32 +++
 rtl/radix_str_seq.sv | 142 ++++++++++++++
 tb/tb_radix_str_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radix_pkg.sv
// rtl/radix_pkg.sv - shared types and constants for the serial ASCII radix converter
package radix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] BASE_MIN = 5'd2;
    localparam logic [4:0] BASE_MAX = 5'd16;

    localparam logic [7:0] ASCII_NUL = 8'h00;
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;
    localparam logic [7:0] ASCII_UA  = 8'h41;
    localparam logic [7:0] ASCII_UF  = 8'h46;
    localparam logic [7:0] ASCII_LA  = 8'h61;
    localparam logic [7:0] ASCII_LF  = 8'h66;

endpackage

// File: rtl/radix_char_decode.sv
// rtl/radix_char_decode.sv - combinational ASCII digit decoder with radix range check
module radix_char_decode
    import radix_pkg::*;
(
    input  logic [7:0] chr,
    input  logic [4:0] base,
    output logic [3:0] digit,
    output logic       is_nul,
    output logic       legal
);

    logic is_digit;

    always_comb begin
        digit    = 4'd0;
        is_digit = 1'b0;
        is_nul   = (chr == ASCII_NUL);
        if (chr >= ASCII_0 && chr <= ASCII_9) begin
            digit    = 4'(chr - ASCII_0);
            is_digit = 1'b1;
        end else if (chr >= ASCII_UA && chr <= ASCII_UF) begin
            digit    = 4'(chr - ASCII_UA + 8'd10);
            is_digit = 1'b1;
        end else if (chr >= ASCII_LA && chr <= ASCII_LF) begin
            digit    = 4'(chr - ASCII_LA + 8'd10);
            is_digit = 1'b1;
        end
        // NUL is never legal here; leading-pad skipping is decided by the caller
        legal = is_digit && ({1'b0, digit} < base);
    end

endmodule

// File: rtl/radix_str_seq.sv
// rtl/radix_str_seq.sv - serial ASCII-to-binary converter; RADIX_STR_SEQ_OVF_DET_EN enables overflow abort
module radix_str_seq
    import radix_pkg::*;
#(
    parameter int NCHAR = 16,
    parameter int OUT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*NCHAR-1:0] num_str,
    input  logic [4:0]         base,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   decimal,
    output logic               err_base,
    output logic               err_char,
    output logic               err_ovf,
    output logic               busy
);

    localparam int IDX_W = (NCHAR > 1) ? $clog2(NCHAR) : 1;

    state_t             state;
    logic [8*NCHAR-1:0] shreg;
    logic [4:0]         base_q;
    logic               base_bad;
    logic [IDX_W-1:0]   idx;
    logic [OUT_W-1:0]   acc;
    logic               seen_digit;
    logic [OUT_W-1:0]   acc_next;
    logic               last_char;

    logic [3:0] dec_digit;
    logic       dec_is_nul;
    logic       dec_legal;

    radix_char_decode u_decode (
        .chr    (shreg[8*NCHAR-1 -: 8]),
        .base   (base_q),
        .digit  (dec_digit),
        .is_nul (dec_is_nul),
        .legal  (dec_legal)
    );

    assign last_char = (idx == '0);
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

`ifdef RADIX_STR_SEQ_OVF_DET_EN
    localparam int PW = OUT_W + 5;
    logic [PW-1:0] prod_wide;
    logic          ovf;
    logic          err_ovf_q;

    assign prod_wide = PW'(acc) * PW'(base_q) + PW'(dec_digit);
    assign acc_next  = prod_wide[OUT_W-1:0];
    assign ovf       = |prod_wide[PW-1:OUT_W];
    assign err_ovf   = err_ovf_q;
`else
    assign acc_next  = acc * OUT_W'(base_q) + OUT_W'(dec_digit);
    assign err_ovf   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            base_q     <= '0;
            base_bad   <= 1'b0;
            idx        <= '0;
            acc        <= '0;
            seen_digit <= 1'b0;
            decimal    <= '0;
            err_base   <= 1'b0;
            err_char   <= 1'b0;
`ifdef RADIX_STR_SEQ_OVF_DET_EN
            err_ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shreg      <= num_str;
                        base_q     <= base;
                        base_bad   <= (base < BASE_MIN) || (base > BASE_MAX);
                        idx        <= IDX_W'(NCHAR - 1);
                        acc        <= '0;
                        seen_digit <= 1'b0;
                        decimal    <= '0;
                        err_base   <= 1'b0;
                        err_char   <= 1'b0;
`ifdef RADIX_STR_SEQ_OVF_DET_EN
                        err_ovf_q  <= 1'b0;
`endif
                        state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    shreg <= shreg << 8;
                    idx   <= idx - IDX_W'(1);
                    // Bad base is reported on the first scan cycle so it lands one cycle after accept
                    if (base_bad) begin
                        err_base <= 1'b1;
                        state    <= ST_DONE;
                    end else if (dec_is_nul && !seen_digit) begin
                        if (last_char) begin
                            decimal <= acc;
                            state   <= ST_DONE;
                        end
                    end else if (!dec_legal) begin
                        err_char <= 1'b1;
                        acc      <= '0;
                        state    <= ST_DONE;
`ifdef RADIX_STR_SEQ_OVF_DET_EN
                    end else if (ovf) begin
                        err_ovf_q <= 1'b1;
                        acc       <= '0;
                        state     <= ST_DONE;
`endif
                    end else begin
                        acc        <= acc_next;
                        seen_digit <= 1'b1;
                        if (last_char) begin
                            decimal <= acc_next;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_radix_str_seq.sv
// tb/tb_radix_str_seq.sv - scoreboard bench for radix_str_seq
module tb_radix_str_seq;

    localparam int NCHAR = 16;
    localparam int OUT_W = 32;
`ifdef RADIX_STR_SEQ_OVF_DET_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [OUT_W-1:0] dec;
        bit               eb;
        bit               ec;
        bit               eo;
        int               lat;
        longint           acc_cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [8*NCHAR-1:0] num_str;
    logic [4:0]         base;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   decimal;
    logic               err_base;
    logic               err_char;
    logic               err_ovf;
    logic               busy;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc   = 0;
    exp_t   sb[$];

    radix_str_seq #(.NCHAR(NCHAR), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num_str   (num_str),
        .base      (base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .decimal   (decimal),
        .err_base  (err_base),
        .err_char  (err_char),
        .err_ovf   (err_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8*NCHAR-1:0] mk(input string s);
        logic [8*NCHAR-1:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) v[8*i +: 8] = s[s.len()-1-i];
        return v;
    endfunction

    function automatic int dval(input byte c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    function automatic exp_t model(input string s, input int b);
        exp_t            e;
        longint unsigned a;
        int              d;
        e = '{dec: '0, eb: 1'b0, ec: 1'b0, eo: 1'b0, lat: NCHAR, acc_cyc: 0};
        a = 0;
        if (b < 2 || b > 16) begin
            e.eb  = 1'b1;
            e.lat = 1;
            return e;
        end
        for (int i = 0; i < s.len(); i++) begin
            d = dval(s[i]);
            if (d < 0 || d >= b) begin
                e.ec  = 1'b1;
                e.lat = NCHAR - (s.len() - 1 - i);
                return e;
            end
            a = a * longint'(b) + longint'(d);
            if (OVF_EN && a >= 64'h1_0000_0000) begin
                e.eo  = 1'b1;
                e.lat = NCHAR - (s.len() - 1 - i);
                return e;
            end
            a = a & 64'hFFFF_FFFF;
        end
        e.dec = a[OUT_W-1:0];
        return e;
    endfunction

    task automatic send(input string s, input int b);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_bad++;
            $display("FAIL send_ready '%s': in_ready=%0b required 1", s, in_ready);
        end
        in_valid = 1'b1;
        num_str  = mk(s);
        base     = 5'(b);
        @(negedge clk);
        in_valid = 1'b0;
        e = model(s, b);
        e.acc_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic drain_one(input string tag);
        exp_t e;
        int   w;
        w = 0;
        while (!out_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        e = sb.pop_front();
        n_cmp++;
        if (!out_valid) begin
            n_bad++;
            $display("FAIL %s_timeout: out_valid=0 required 1 within 200 cycles", tag);
            return;
        end
        n_cmp++;
        if (decimal !== e.dec) begin
            n_bad++;
            $display("FAIL %s_decimal: got %0d required %0d", tag, decimal, e.dec);
        end
        n_cmp++;
        if ({err_base, err_char, err_ovf} !== {e.eb, e.ec, e.eo}) begin
            n_bad++;
            $display("FAIL %s_flags: got b/c/o=%b%b%b required %b%b%b", tag,
                     err_base, err_char, err_ovf, e.eb, e.ec, e.eo);
        end
        n_cmp++;
        if (cyc - e.acc_cyc !== longint'(e.lat)) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d required %0d", tag, cyc - e.acc_cyc, e.lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, busy, err_base, err_char, err_ovf} !== 6'b100000 || decimal !== '0) begin
            n_bad++;
            $display("FAIL reset: rdy/vld/busy/eb/ec/eo=%b%b%b%b%b%b dec=%0d required 100000 dec=0",
                     in_ready, out_valid, busy, err_base, err_char, err_ovf, decimal);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_convert();
        send("1010", 2);
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL scan_busy: in_ready=%b busy=%b required 0 1", in_ready, busy);
        end
        drain_one("bin_1010");
        send("7F", 16);        drain_one("hex_7F");
        send("77", 8);         drain_one("oct_77");
        send("7f", 16);        drain_one("hex_7f");
        send("", 10);          drain_one("all_nul");
        send("FFFFFFFF", 16);  drain_one("hex_max");
        send("4294967295", 10); drain_one("dec_max");
    endtask

    task automatic test_errors();
        send("G1", 16);  drain_one("bad_char_G");
        send("19", 9);   drain_one("digit_ge_base");
        send("123", 1);  drain_one("base_1");
        send("123", 17); drain_one("base_17");
        send("10", 0);   drain_one("base_0");
    endtask

    task automatic test_overflow();
        send("100000000", 16);
        drain_one("ovf_16_8");
        send("FFFFFFFF0", 16);
        drain_one("ovf_wrap2");
    endtask

    task automatic test_back_to_back();
        logic [OUT_W-1:0] d0;
        int               w;
        out_ready = 1'b0;
        send("7F", 16);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        d0 = decimal;
        n_cmp++;
        if (d0 !== 32'd127) begin
            n_bad++;
            $display("FAIL stall_value: got %0d required 127", d0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || decimal !== d0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: vld=%b dec=%0d rdy=%b busy=%b required 1 127 0 1",
                         i, out_valid, decimal, in_ready, busy);
            end
        end
        void'(sb.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        in_valid = 1'b1;
        num_str  = mk("ab");
        base     = 5'd16;
        @(negedge clk);
        in_valid = 1'b0;
        begin
            exp_t e;
            e = model("ab", 16);
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        drain_one("b2b_ab");
        send("255", 10);
        drain_one("b2b_255");
    endtask

    task automatic test_reset_mid_scan();
        send("1010", 2);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb.pop_front());
        n_cmp++;
        if ({in_ready, out_valid, busy, err_base, err_char, err_ovf} !== 6'b100000 || decimal !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: rdy/vld/busy/eb/ec/eo=%b%b%b%b%b%b dec=%0d required 100000 dec=0",
                     in_ready, out_valid, busy, err_base, err_char, err_ovf, decimal);
        end
        send("123", 10);
        drain_one("after_reset");
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        num_str   = '0;
        base      = 5'd0;
        out_ready = 1'b1;
        test_reset();
        test_convert();
        test_errors();
        test_overflow();
        test_back_to_back();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
